// File: rtl/lampfpu_div_arbiter_if.sv
// Requester-side bundle of the shared FP divider arbiter: request and response
// handshakes. The master modport is the requester side and the slave modport is the arbiter side.
interface lampfpu_div_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 16
);
    logic [NUM_REQ-1:0]    req_valid_i;
    logic [NUM_REQ-1:0]    req_ready_o;
    logic [NUM_REQ*DW-1:0] req_op1_i;
    logic [NUM_REQ*DW-1:0] req_op2_i;
    logic [NUM_REQ-1:0]    req_rnd_i;
    logic [NUM_REQ-1:0]    rsp_valid_o;
    logic [NUM_REQ-1:0]    rsp_ready_i;
    logic [DW-1:0]         rsp_data_o;

    modport master (
        output req_valid_i, req_op1_i, req_op2_i, req_rnd_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_op1_i, req_op2_i, req_rnd_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/lampfpu_div_arbiter.sv
// Round-robin arbiter sharing one FP divider (do/padv handshake) among NUM_REQ requesters.
// Define LAMPFPU_DIV_ARB_STATS_EN to enable the per-requester saturating grant counters on gnt_cnt_o.
module lampfpu_div_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DW      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    lampfpu_div_arbiter_if.slave  req,
    output logic                  busy_o,
    output logic                  div_do_o,
    output logic                  div_padv_o,
    output logic                  div_rnd_o,
    output logic [DW-1:0]         div_op1_o,
    output logic [DW-1:0]         div_op2_o,
    input  logic [DW-1:0]         div_result_i,
    input  logic                  div_valid_i,
    input  logic                  div_ready_i,
    output logic [NUM_REQ*8-1:0]  gnt_cnt_o
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t             r_state, w_next;
    logic [IW-1:0]      r_ptr, r_idx, w_win, w_ptr_nxt;
    logic [DW-1:0]      r_op1, r_op2, r_res;
    logic               r_rnd;
    logic               w_any, w_start, w_rsp_hs, w_rnd;
    logic [NUM_REQ-1:0] w_win_oh, w_idx_oh;
    logic [DW-1:0]      w_op1, w_op2;

    // Winner is the first valid requester at or after r_ptr, wrapping around.
    always_comb begin
        w_win = '0;
        w_any = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                if (!w_any && req.req_valid_i[i] && (((32'(r_ptr) + k) % NUM_REQ) == i)) begin
                    w_win = IW'(i);
                    w_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_win_oh = '0;
        w_idx_oh = '0;
        w_op1    = '0;
        w_op2    = '0;
        w_rnd    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == IW'(i)) begin
                w_win_oh[i] = 1'b1;
                w_op1       = req.req_op1_i[i*DW +: DW];
                w_op2       = req.req_op2_i[i*DW +: DW];
                w_rnd       = req.req_rnd_i[i];
            end
            if (r_idx == IW'(i)) begin
                w_idx_oh[i] = 1'b1;
            end
        end
    end

    assign w_start   = (r_state == IDLE) && w_any && div_ready_i && !div_valid_i && !rst;
    assign w_rsp_hs  = (r_state == RESP) && |(req.rsp_ready_i & w_idx_oh) && !rst;
    assign w_ptr_nxt = (32'(w_win) == NUM_REQ - 1) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_start) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (div_valid_i) w_next = RESP;
            RESP:    if (w_rsp_hs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy_o          = (r_state != IDLE);
        div_do_o        = (r_state == ISSUE);
        div_padv_o      = w_rsp_hs;
        req.req_ready_o = w_start ? w_win_oh : '0;
        req.rsp_valid_o = (r_state == RESP) ? w_idx_oh : '0;
        req.rsp_data_o  = r_res;
        div_op1_o       = r_op1;
        div_op2_o       = r_op2;
        div_rnd_o       = r_rnd;
    end

    // Operands and grant index stay latched until the next grant, so the divider sees them stable.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
            r_idx <= '0;
            r_op1 <= '0;
            r_op2 <= '0;
            r_rnd <= 1'b0;
            r_res <= '0;
        end else begin
            if (w_start) begin
                r_ptr <= w_ptr_nxt;
                r_idx <= w_win;
                r_op1 <= w_op1;
                r_op2 <= w_op2;
                r_rnd <= w_rnd;
            end
            if ((r_state == WAIT) && div_valid_i) begin
                r_res <= div_result_i;
            end
        end
    end

`ifdef LAMPFPU_DIV_ARB_STATS_EN
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cnt
        logic [7:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (req.req_ready_o[gi] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 8'd1;
            end
        end
        assign gnt_cnt_o[gi*8 +: 8] = r_cnt;
    end
`else
    assign gnt_cnt_o = '0;
`endif
endmodule

// File: tb/tb_lampfpu_div_arbiter.sv
// Scoreboard bench for lampfpu_div_arbiter with a small behavioural divider model.
// Honours LAMPFPU_DIV_ARB_STATS_EN for the grant-counter expectations.
module tb_lampfpu_div_arbiter;
    localparam int NR = 4;
    localparam int DW = 16;

    typedef struct {
        int          idx;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic stall = 1'b0;
    logic m_ready, m_valid, m_active;
    logic [15:0] m_result, m_res;
    int m_cnt;
    int lat = 1;

    logic [NR-1:0]    rsp_rdy = '1;
    logic [NR*DW-1:0] op1_v = '0;
    logic [NR*DW-1:0] op2_v = '0;
    logic [NR-1:0]    rnd_v = '0;
    logic [NR-1:0]    req_valid;
    logic [NR-1:0]    g;
    int post_cnt [NR] = '{default: 0};
    int acc_cnt  [NR] = '{default: 0};

    logic busy, div_do, div_padv, div_rnd;
    logic [DW-1:0] div_op1, div_op2;
    logic [NR*8-1:0] gnt_cnt;
    logic div_ready;

    int n_cmp = 0;
    int n_fail = 0;
    int n_do = 0;
    int n_padv = 0;
    exp_t sb[$];

    lampfpu_div_arbiter_if #(.NUM_REQ(NR), .DW(DW)) rif ();

    assign rif.req_valid_i = req_valid;
    assign rif.req_op1_i   = op1_v;
    assign rif.req_op2_i   = op2_v;
    assign rif.req_rnd_i   = rnd_v;
    assign rif.rsp_ready_i = rsp_rdy;
    assign div_ready       = m_ready & ~stall;

    lampfpu_div_arbiter #(.NUM_REQ(NR), .DW(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (rif),
        .busy_o       (busy),
        .div_do_o     (div_do),
        .div_padv_o   (div_padv),
        .div_rnd_o    (div_rnd),
        .div_op1_o    (div_op1),
        .div_op2_o    (div_op2),
        .div_result_i (m_result),
        .div_valid_i  (m_valid),
        .div_ready_i  (div_ready),
        .gnt_cnt_o    (gnt_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_valid = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            req_valid[i] = (post_cnt[i] != acc_cnt[i]);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] div_lut(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'h40C0_4000: return 16'h4040;
            32'h3F80_3F80: return 16'h3F80;
            32'h4040_3F80: return 16'h4040;
            default:       return 16'hDEAD;
        endcase
    endfunction

    task automatic expect_rsp(input int i, input logic [15:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic post(input int i, input logic [15:0] a, input logic [15:0] b, input logic r);
        op1_v[i*DW +: DW] = a;
        op2_v[i*DW +: DW] = b;
        rnd_v[i]          = r;
        post_cnt[i]       = post_cnt[i] + 1;
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string nm);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (req_valid == '0 && sb.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1'b1);
    endtask

    task automatic do_reset();
        sync();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Divider model: result a fixed latency after do, held until padv.
    initial begin
        logic s_do, s_padv, s_rst;
        m_ready = 1'b1; m_valid = 1'b0; m_active = 1'b0;
        m_result = '0; m_res = '0; m_cnt = 0;
        forever begin
            @(negedge clk);
            s_do = div_do; s_padv = div_padv; s_rst = rst;
            @(posedge clk);
            #1;
            if (s_rst) begin
                m_ready = 1'b1; m_valid = 1'b0; m_active = 1'b0;
            end else if (s_padv) begin
                m_ready = 1'b1; m_valid = 1'b0; m_active = 1'b0;
            end else if (s_do) begin
                m_active = 1'b1; m_ready = 1'b0; m_cnt = lat;
                m_res = div_lut(div_op1, div_op2);
            end else if (m_active && !m_valid) begin
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_result = m_res;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Requester driver: holds each request until its accept pulse.
    initial begin
        g = '0;
        forever begin
            @(negedge clk);
            g = rif.req_ready_o & req_valid;
            @(posedge clk);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (g[i]) acc_cnt[i] = acc_cnt[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (div_do) n_do++;
            if (div_padv) n_padv++;
            if ((rif.rsp_valid_o & rif.rsp_ready_i) != '0) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 64'(rif.rsp_valid_o), 64'h0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_onehot", 64'(rif.rsp_valid_o), 64'(1) << e.idx);
                    chk("rsp_data", 64'(rif.rsp_data_o), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, p0;
        logic ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_req_ready", 64'(rif.req_ready_o), 64'h0);
        chk("rst_rsp_valid", 64'(rif.rsp_valid_o), 64'h0);
        chk("rst_do_padv", {div_do, div_padv}, 2'b00);
        chk("rst_ops", {div_rnd, div_op1, div_op2}, 33'h0);
        chk("rst_rsp_data", 64'(rif.rsp_data_o), 64'h0);
        chk("rst_gnt_cnt", 64'(gnt_cnt), 64'h0);

        // Single request: 6.0 / 2.0 = 3.0
        d0 = n_do; p0 = n_padv;
        expect_rsp(0, 16'h4040);
        sync();
        post(0, 16'h40C0, 16'h4000, 1'b0);
        wait_idle("t1_done");
        chk("t1_do_count", 64'(n_do - d0), 64'd1);
        chk("t1_padv_count", 64'(n_padv - p0), 64'd1);
        chk("t1_ops", {div_rnd, div_op1, div_op2}, {1'b0, 16'h40C0, 16'h4000});
        chk("t1_data_held", 64'(rif.rsp_data_o), 64'h4040);

        // Four simultaneous requests from pointer 0, then 0 and 2 again.
        do_reset();
        for (int i = 0; i < NR; i++) expect_rsp(i, 16'h3F80);
        sync();
        for (int i = 0; i < NR; i++) post(i, 16'h3F80, 16'h3F80, 1'b0);
        wait_idle("t2_all4");
        expect_rsp(0, 16'h3F80);
        expect_rsp(2, 16'h3F80);
        sync();
        post(0, 16'h3F80, 16'h3F80, 1'b0);
        post(2, 16'h3F80, 16'h3F80, 1'b0);
        wait_idle("t2_pair");

        // Backpressure on requester 1 while requester 0 waits.
        expect_rsp(1, 16'h3F80);
        expect_rsp(0, 16'h3F80);
        sync();
        rsp_rdy = 4'b1101;
        post(1, 16'h3F80, 16'h3F80, 1'b1);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (rif.rsp_valid_o == 4'b0010) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t3_reach_resp", ok, 1'b1);
        sync();
        post(0, 16'h3F80, 16'h3F80, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t3_rsp_valid", 64'(rif.rsp_valid_o), 64'h2);
            chk("t3_rsp_data", 64'(rif.rsp_data_o), 64'h3F80);
            chk("t3_no_padv_grant", {div_padv, rif.req_ready_o}, 5'b0);
        end
        sync();
        rsp_rdy = '1;
        @(negedge clk);
        chk("t3_padv", div_padv, 1'b1);
        chk("t3_no_grant_yet", 64'(rif.req_ready_o), 64'h0);
        @(negedge clk);
        chk("t3_regrant", {div_padv, rif.req_ready_o}, 5'b0_0001);
        wait_idle("t3_done");

        // Reset while waiting on the divider; the op is discarded.
        lat = 6;
        sync();
        post(2, 16'h40C0, 16'h4000, 1'b0);
        ok = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (div_do) begin
                ok = 1'b1;
                break;
            end
        end
        chk("t4_issue", ok, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("t4_busy_wait", {busy, rif.rsp_valid_o}, 5'b1_0000);
        sync();
        rst = 1'b1;
        sync();
        rst = 1'b0;
        @(negedge clk);
        chk("t4_busy", busy, 1'b0);
        chk("t4_pulses", {div_do, div_padv, rif.req_ready_o, rif.rsp_valid_o}, 10'h0);
        chk("t4_ops", {div_rnd, div_op1, div_op2}, 33'h0);
        chk("t4_rsp_data", 64'(rif.rsp_data_o), 64'h0);
        lat = 1;
        expect_rsp(3, 16'h4040);
        sync();
        post(3, 16'h4040, 16'h3F80, 1'b1);
        wait_idle("t4_req3");
        chk("t4_rnd", div_rnd, 1'b1);

        // Divider not ready: no accept, no start.
        d0 = n_do;
        expect_rsp(1, 16'h3F80);
        sync();
        stall = 1'b1;
        post(1, 16'h3F80, 16'h3F80, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("t5_stalled", {div_do, rif.req_ready_o}, 5'b0);
        end
        chk("t5_no_do", 64'(n_do - d0), 64'd0);
        sync();
        stall = 1'b0;
        wait_idle("t5_done");
        chk("t5_one_do", 64'(n_do - d0), 64'd1);

        // Grant counters.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            expect_rsp(2, 16'h3F80);
            sync();
            post(2, 16'h3F80, 16'h3F80, 1'b0);
            wait_idle("t6_grant");
            if (k == 9) begin
`ifdef LAMPFPU_DIV_ARB_STATS_EN
                chk("t6_cnt_10", 64'(gnt_cnt), 64'h000A_0000);
`else
                chk("t6_cnt_off_10", 64'(gnt_cnt), 64'h0);
`endif
            end
        end
`ifdef LAMPFPU_DIV_ARB_STATS_EN
        chk("t6_cnt_sat", 64'(gnt_cnt), 64'h00FF_0000);
`else
        chk("t6_cnt_off", 64'(gnt_cnt), 64'h0);
`endif
        chk("sb_empty", 64'(sb.size()), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
